// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline controller.
//   - stall vector width and the named stall patterns (none, ID, EX)
//   - controller state encodings
//   - instruction address width, enable/disable levels, zero word
package pipe_ctrl_pkg;

  localparam int STALL_W     = 6;
  localparam int INST_ADDR_W = 32;  // InstAddrBus width
  localparam int CYC_W       = 6;   // width of the multi-cycle occupancy count

  // Stall vectors are prefix-contiguous: bit0 = PC ... bit5 = WB.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;  // hold PC/IF/ID, bubble into EX
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;  // hold PC/IF/ID/EX

  localparam logic                   ENABLE    = 1'b1;
  localparam logic                   DISABLE   = 1'b0;
  localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_multi_cycle_timer.sv
// multi_cycle_timer: down-counter tracking the remaining EX occupancy of a
// multi-cycle operation.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_load          : load counter with i_cycles - 1 (start cycle)
//   i_cycles        : total occupancy N of the starting operation
//   i_dec           : decrement by one (each MULTI cycle)
//   i_clear         : clear counter (flush abort)
//   o_last          : counter is 1, i.e. this is the final occupancy cycle
module multi_cycle_timer
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CYC_W-1:0] i_cycles,
  input  logic             i_dec,
  input  logic             i_clear,
  output logic             o_last
);

  logic [CYC_W-1:0] r_cnt;

  // The start cycle itself counts as one cycle of occupancy, hence N-1.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_cycles - CYC_W'(1);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CYC_W'(1);
    end
  end

  assign o_last = (r_cnt == CYC_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/flush controller.
// Resolves per-cycle priority flush > multi-cycle op > EX stall > ID stall
// and produces the per-stage hold vector, flush strobe and redirect PC.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stallreq_id_i     : ID-stage stall request
//   stallreq_ex_i     : EX-stage single-cycle stall request
//   multi_start_i     : EX starts a multi-cycle operation
//   multi_cycles_i    : occupancy N of that operation
//   flush_req_i       : exception/redirect flush request
//   flush_pc_i        : redirect target
//   stall_o           : per-stage hold, bit0 = PC ... bit5 = WB
//   flush_o           : clear all pipeline registers this cycle
//   new_pc_o          : PC load value, zero unless flush_o
//   busy_o            : multi-cycle operation in progress
//   multi_done_o      : pulse on the final cycle of a multi-cycle operation
//   stall_cnt_o       : count of cycles with the PC held (only with
//                       PIPE_CTRL_STALL_STAT_EN defined)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_id_i,
  input  logic                   stallreq_ex_i,
  input  logic                   multi_start_i,
  input  logic [CYC_W-1:0]       multi_cycles_i,
  input  logic                   flush_req_i,
  input  logic [INST_ADDR_W-1:0] flush_pc_i,
  output logic [STALL_W-1:0]     stall_o,
  output logic                   flush_o,
  output logic [INST_ADDR_W-1:0] new_pc_o,
  output logic                   busy_o,
  output logic                   multi_done_o
`ifdef PIPE_CTRL_STALL_STAT_EN
  ,
  output logic [31:0]            stall_cnt_o
`endif
);

  ctrl_state_t            r_state;
  ctrl_state_t            w_next_state;
  logic [STALL_W-1:0]     w_stall;
  logic                   w_flush;
  logic [INST_ADDR_W-1:0] w_new_pc;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_load;
  logic                   w_dec;
  logic                   w_clear;
  logic                   w_last;
  logic                   w_long_op;

  // N of 0 or 1 completes in the start cycle and never enters MULTI.
  assign w_long_op = multi_start_i && (multi_cycles_i >= CYC_W'(2));

  multi_cycle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_cycles (multi_cycles_i),
    .i_dec    (w_dec),
    .i_clear  (w_clear),
    .o_last   (w_last)
  );

  always_comb begin
    w_next_state = r_state;
    w_stall      = STALL_NONE;
    w_flush      = DISABLE;
    w_new_pc     = ZERO_WORD;
    w_busy       = (r_state == ST_MULTI);
    w_done       = DISABLE;
    w_load       = DISABLE;
    w_dec        = DISABLE;
    w_clear      = DISABLE;
    if (flush_req_i) begin
      // Flush wins in every state and aborts any multi-cycle op silently.
      w_flush      = ENABLE;
      w_new_pc     = flush_pc_i;
      w_clear      = ENABLE;
      w_next_state = ST_FLUSH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_long_op) begin
            w_stall      = STALL_EX;
            w_load       = ENABLE;
            w_next_state = ST_MULTI;
          end else if (multi_start_i) begin
            w_done = ENABLE;
          end else if (stallreq_ex_i) begin
            w_stall = STALL_EX;
          end else if (stallreq_id_i) begin
            w_stall = STALL_ID;
          end
        end
        ST_MULTI: begin
          w_dec = ENABLE;
          if (w_last) begin
            // Final cycle: EX result is ready, release the front end.
            w_done       = ENABLE;
            w_next_state = ST_IDLE;
          end else begin
            w_stall = STALL_EX;
          end
        end
        ST_FLUSH: begin
          w_next_state = ST_IDLE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Reset masks every output regardless of what the inputs request.
  assign stall_o      = rst ? STALL_NONE : w_stall;
  assign flush_o      = rst ? DISABLE    : w_flush;
  assign new_pc_o     = rst ? ZERO_WORD  : w_new_pc;
  assign busy_o       = rst ? DISABLE    : w_busy;
  assign multi_done_o = rst ? DISABLE    : w_done;

`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [31:0] r_stall_cnt;

  // Counts PC-hold cycles; wraps naturally and survives flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (stall_o[0]) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl. Directed sequences for the
// named scenarios followed by randomized traffic, all compared every cycle
// against a cycle-count reference model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        multi_start_i;
  logic [5:0]  multi_cycles_i;
  logic        flush_req_i;
  logic [31:0] flush_pc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic        multi_done_o;
`ifdef PIPE_CTRL_STALL_STAT_EN
  logic [31:0] stall_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .multi_start_i  (multi_start_i),
    .multi_cycles_i (multi_cycles_i),
    .flush_req_i    (flush_req_i),
    .flush_pc_i     (flush_pc_i),
    .stall_o        (stall_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .busy_o         (busy_o),
    .multi_done_o   (multi_done_o)
`ifdef PIPE_CTRL_STALL_STAT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: cycles of EX occupancy still owed after the current
  // cycle, and whether the previous cycle was a flush.
  int          m_rem     = 0;
  bit          m_flushed = 1'b0;
  logic [31:0] m_cnt     = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare all outputs, advance the model.
  task automatic cycle(input bit r, input bit id, input bit ex, input bit st,
                       input int n, input bit f, input logic [31:0] pc);
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    bit          e_flush, e_busy, e_done;
    @(negedge clk);
    rst            = r;
    stallreq_id_i  = id;
    stallreq_ex_i  = ex;
    multi_start_i  = st;
    multi_cycles_i = n[5:0];
    flush_req_i    = f;
    flush_pc_i     = pc;
    e_stall = 6'b000000; e_pc = 32'h0; e_flush = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (r) begin
      m_rem = 0; m_flushed = 1'b0;
    end else if (f) begin
      e_flush = 1'b1; e_pc = pc; e_busy = (m_rem > 0);
      m_rem = 0; m_flushed = 1'b1;
    end else if (m_rem > 0) begin
      e_busy = 1'b1;
      if (m_rem == 1) e_done = 1'b1;
      else            e_stall = 6'b001111;
      m_rem = m_rem - 1;
    end else if (m_flushed) begin
      m_flushed = 1'b0;
    end else if (st && n >= 2) begin
      e_stall = 6'b001111;
      m_rem = n - 1;
    end else if (st) begin
      e_done = 1'b1;
    end else if (ex) begin
      e_stall = 6'b001111;
    end else if (id) begin
      e_stall = 6'b000111;
    end
    #1;
    chk("stall", 32'(stall_o), 32'(e_stall));
    chk("flush", 32'(flush_o), 32'(e_flush));
    chk("new_pc", new_pc_o, e_pc);
    chk("busy", 32'(busy_o), 32'(e_busy));
    chk("done", 32'(multi_done_o), 32'(e_done));
`ifdef PIPE_CTRL_STALL_STAT_EN
    chk("stall_cnt", stall_cnt_o, m_cnt);
    if (r) m_cnt = 32'd0;
    else if (e_stall[0]) m_cnt = m_cnt + 32'd1;
`endif
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0; multi_start_i = 1'b0;
    multi_cycles_i = 6'd0; flush_req_i = 1'b0; flush_pc_i = 32'h0;

    // Reset with noisy inputs: every output must stay zero.
    cycle(1, 1, 1, 1, 5, 1, 32'hDEAD_BEEF);
    cycle(1, 0, 1, 0, 0, 0, 32'h0);
    idle(1);

    // ID stall for one cycle.
    cycle(0, 1, 0, 0, 0, 0, 32'h0);
    idle(1);

    // N = 5 multi-cycle operation, with requests that must be ignored.
    cycle(0, 0, 0, 1, 5, 0, 32'h0);
    cycle(0, 1, 1, 1, 3, 0, 32'h0);
    idle(3);
    idle(1);

    // Flush on the 3rd cycle of an N = 8 operation.
    cycle(0, 0, 0, 1, 8, 0, 32'h0);
    idle(1);
    cycle(0, 0, 0, 0, 0, 1, 32'hBFC0_0380);
    chk("redirect_pc", new_pc_o, 32'hBFC0_0380);
    cycle(0, 1, 1, 1, 4, 0, 32'h0);  // FLUSH cycle ignores everything
    cycle(0, 1, 0, 0, 0, 0, 32'h0);  // back in IDLE
    idle(1);

    // Back-to-back flushes, and ID+EX together.
    cycle(0, 0, 0, 0, 0, 1, 32'h1234_5678);
    cycle(0, 0, 0, 0, 0, 1, 32'h8000_0000);
    idle(1);
    cycle(0, 1, 1, 0, 0, 0, 32'h0);

    // Single-cycle operations.
    cycle(0, 0, 0, 1, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 1, 0, 32'h0);
    cycle(0, 0, 0, 1, 2, 0, 32'h0);
    idle(2);

    // Reset on the 2nd cycle of an N = 6 operation.
    cycle(0, 0, 0, 1, 6, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    cycle(1, 1, 0, 0, 0, 0, 32'h0);
    idle(6);

`ifdef PIPE_CTRL_STALL_STAT_EN
    // Stall counter: N = 5 gives 4 PC-hold cycles, flush leaves it alone.
    cycle(1, 0, 0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 5, 0, 32'h0);
    idle(4);
    cycle(0, 0, 0, 0, 0, 1, 32'h0000_0100);
    idle(1);
    chk("cnt_after_flush", stall_cnt_o, 32'd4);
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    cycle(0, 0, 1, 0, 0, 0, 32'h0);
    idle(1);
    chk("cnt_wrap", stall_cnt_o, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 99) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 10)),
            $urandom_range(0, 24) == 0,
            $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1: rising-edge clock.
REQ-002 SHALL have `rst`, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have `stallreq_id_i`, input, 1: ID-stage stall request (load-use or operand not ready).
REQ-004 SHALL have `stallreq_ex_i`, input, 1: EX-stage single-cycle stall request.
REQ-005 SHALL have `multi_start_i`, input, 1: EX starts a multi-cycle operation (mult/div).
REQ-006 SHALL have `multi_cycles_i`, input, 6: EX occupancy N of that operation, in cycles.
REQ-007 SHALL have `flush_req_i`, input, 1: exception/redirect flush request.
REQ-008 SHALL have `flush_pc_i`, input, 32: redirect target address.
REQ-009 SHALL have `stall_o`, output, 6: per-stage hold, bit0 = PC, bit1 = IF, bit2 = ID, bit3 = EX, bit4 = MEM, bit5 = WB.
REQ-010 SHALL have `flush_o`, output, 1: clear all pipeline registers this cycle.
REQ-011 SHALL have `new_pc_o`, output, 32: PC load value, valid while `flush_o` = 1.
REQ-012 SHALL have `busy_o`, output, 1: multi-cycle operation in progress.
REQ-013 SHALL have `multi_done_o`, output, 1: one-cycle pulse on the final cycle of a multi-cycle operation.

Function
REQ-014 SHALL implement three states: IDLE, MULTI and FLUSH.
REQ-015 SHALL resolve priority per cycle in this order, highest first: flush, MULTI, `stallreq_ex_i`, `stallreq_id_i`.
REQ-016 SHALL drive `flush_o` = 1, `new_pc_o` = `flush_pc_i` and `stall_o` = 6'b000000 combinationally in the same cycle `flush_req_i` = 1, in any state; next state FLUSH.
REQ-017 SHALL hold `new_pc_o` = 32'h0 whenever `flush_o` = 0.
REQ-018 SHALL, in FLUSH, for exactly one cycle:
- ignore all stall requests and `multi_start_i`;
- drive `stall_o` = 0;
- move to IDLE, unless `flush_req_i` = 1 again, in which case REQ-016 applies and the state stays FLUSH.
REQ-019 SHALL, in IDLE, when `multi_start_i` = 1 and N ≥ 2 (no flush):
- load a down-counter with N-1;
- go to MULTI;
- drive `stall_o` = 6'b001111 in that same cycle.
REQ-020 SHALL treat N = 0 or N = 1 in IDLE as a single-cycle operation: no state change, `multi_done_o` = 1 that cycle.
REQ-021 SHALL, in MULTI:
- drive `stall_o` = 6'b001111 and `busy_o` = 1;
- decrement the counter each cycle;
- when the counter = 1, drive `multi_done_o` = 1 and `stall_o` = 6'b000000, then return to IDLE;
- total EX occupancy is exactly N cycles from the start cycle.
REQ-022 SHALL ignore `multi_start_i`, `stallreq_id_i` and `stallreq_ex_i` in MULTI.
REQ-023 SHALL abort MULTI on flush: counter cleared, no `multi_done_o` pulse, next state FLUSH.
REQ-024 SHALL, in IDLE with no flush or multi start:
- drive `stall_o` = 6'b001111 if `stallreq_ex_i` = 1;
- else drive 6'b000111 if `stallreq_id_i` = 1 (bubble inserted into EX);
- else drive 6'b000000.
REQ-025 SHALL keep `stall_o` prefix-contiguous: if bit k = 1 then all lower bits = 1.

Reset
REQ-026 SHALL, on `rst` = 1 at a clock edge:
- set state IDLE and counter 0;
- force `stall_o` = 0, `flush_o` = 0, `new_pc_o` = 32'h0, `busy_o` = 0, `multi_done_o` = 0 while `rst` = 1, regardless of inputs.
REQ-027 SHALL, when `rst` is asserted mid-MULTI, abandon the operation without a `multi_done_o` pulse.

Configuration
REQ-028 SHALL, with macro PIPE_CTRL_STALL_STAT_EN defined:
- add output `stall_cnt_o`, 32 bits;
- increment it at each clock edge where `stall_o`[0] = 1;
- let it wrap from 32'hFFFFFFFF to 0;
- clear it on `rst` and never on flush.
REQ-029 SHALL, without PIPE_CTRL_STALL_STAT_EN, omit `stall_cnt_o` and its counter entirely.

Structure
REQ-030 SHALL take these definitions from the shared defines.v include:
- stall-vector width and named stall patterns (none, ID, EX);
- state encodings;
- `InstAddrBus`, `Enable`/`Disable`, `ZeroWord`.
REQ-031 SHALL place the N-cycle down-counter (load, decrement, last-cycle flag, clear) in one sub-module, `multi_cycle_timer`.

Verification
REQ-032 SHALL cover: `stallreq_id_i` = 1 for 1 cycle in IDLE -> `stall_o` = 6'b000111 that cycle, 6'b000000 next.
REQ-033 SHALL cover: `multi_start_i` = 1, N = 5 -> `stall_o` = 6'b001111 for 4 cycles; `multi_done_o` = 1 and `stall_o` = 0 on the 5th cycle; `busy_o` high on cycles 2–5.
REQ-034 SHALL cover: `flush_req_i` = 1 with `flush_pc_i` = 32'hBFC00380 on the 3rd cycle of an N = 8 operation -> same cycle `flush_o` = 1, `new_pc_o` = 32'hBFC00380, `stall_o` = 0; no `multi_done_o`; FLUSH one cycle, then IDLE.
REQ-035 SHALL cover: `stallreq_id_i` = 1 and `stallreq_ex_i` = 1 together in IDLE -> `stall_o` = 6'b001111; `multi_start_i` with N = 0 and N = 1 -> `multi_done_o` pulse, no stall.
REQ-036 SHALL cover: `rst` = 1 on the 2nd cycle of an N = 6 operation -> all outputs 0 while `rst` = 1; state IDLE after release; no done pulse.
REQ-037 SHALL cover, with PIPE_CTRL_STALL_STAT_EN: the REQ-033 sequence, then a flush -> `stall_cnt_o` = 4, unchanged by the flush; with the counter preloaded via force to 32'hFFFFFFFF, one stall cycle -> 0.
